// File: rtl/pc_sequencer.sv
// Multicycle fetch/wait/decode/execute controller driving the PC control inputs
// and IR load. All outputs are registered; the EXEC decision shows up on the outputs one cycle later.
module pc_sequencer #(
  parameter int AW       = 8,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             mem_ready,
  input  logic             op_jump,
  input  logic             op_branch,
  input  logic             op_halt,
  input  logic [AW-1:0]    target,
  input  logic             cond_flag,
  input  logic             resume,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_stop,
  output logic             pc_wr,
  output logic             if_ban,
  output logic [AW-1:0]    jump,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [1:0] {OP_SEQ, OP_BRANCH, OP_JUMP, OP_HALT} op_t;

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  op_t              op_reg, op_next;
  logic [AW-1:0]    target_reg, target_next;
  logic             mem_req_reg, mem_req_next;
  logic             ir_load_reg, ir_load_next;
  logic             pc_stop_reg, pc_stop_next;
  logic             pc_wr_reg, pc_wr_next;
  logic             if_ban_reg, if_ban_next;
  logic [AW-1:0]    jump_reg, jump_next;
  logic             halted_reg, halted_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             stalled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      op_reg       <= OP_SEQ;
      target_reg   <= '0;
      mem_req_reg  <= 1'b0;
      ir_load_reg  <= 1'b0;
      pc_stop_reg  <= 1'b1;
      pc_wr_reg    <= 1'b0;
      if_ban_reg   <= 1'b0;
      jump_reg     <= '0;
      halted_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      op_reg       <= op_next;
      target_reg   <= target_next;
      mem_req_reg  <= mem_req_next;
      ir_load_reg  <= ir_load_next;
      pc_stop_reg  <= pc_stop_next;
      pc_wr_reg    <= pc_wr_next;
      if_ban_reg   <= if_ban_next;
      jump_reg     <= jump_next;
      halted_reg   <= halted_next;
      fault_reg    <= fault_next;
      retired_reg  <= retired_next;
    end
  end

  // Stall only freezes the active instruction cycle, never IDLE/HALT/FAULT.
  assign stalled = stall && (state_reg == S_FETCH || state_reg == S_WAIT ||
                             state_reg == S_DECODE || state_reg == S_EXEC);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    op_next       = op_reg;
    target_next   = target_reg;
    mem_req_next  = 1'b0;
    ir_load_next  = 1'b0;
    pc_stop_next  = 1'b1;
    pc_wr_next    = 1'b0;
    if_ban_next   = 1'b0;
    jump_next     = jump_reg;
    retired_next  = retired_reg;

    if (!stalled) begin
      case (state_reg)
        S_IDLE: begin
          if (start) state_next = S_FETCH;
        end
        S_FETCH: begin
          wait_cnt_next = '0;
          state_next    = S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_next   = S_DECODE;
            ir_load_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
            if (wait_cnt_reg == 8'(MAX_WAIT - 1)) state_next = S_FAULT;
          end
        end
        S_DECODE: begin
          if (op_halt)        op_next = OP_HALT;
          else if (op_jump)   op_next = OP_JUMP;
          else if (op_branch) op_next = OP_BRANCH;
          else                op_next = OP_SEQ;
          target_next = target;
          state_next  = S_EXEC;
        end
        S_EXEC: begin
          if (op_reg == OP_HALT) begin
            state_next = S_HALT;
          end else begin
            state_next   = S_FETCH;
            pc_stop_next = 1'b0;
            retired_next = retired_reg + CNT_W'(1);
            if (op_reg == OP_JUMP) begin
              pc_wr_next = 1'b1;
              jump_next  = target_reg;
            end else if (op_reg == OP_BRANCH && cond_flag) begin
              if_ban_next = 1'b1;
              jump_next   = target_reg;
            end
          end
        end
        S_HALT: begin
          if (resume) state_next = S_FETCH;
        end
        S_FAULT: ;
        default: state_next = S_IDLE;
      endcase
      mem_req_next = (state_next == S_FETCH) || (state_next == S_WAIT);
    end else begin
      mem_req_next = mem_req_reg;
    end

    halted_next = (state_next == S_HALT);
    fault_next  = (state_next == S_FAULT);
  end

  assign mem_req = mem_req_reg;
  assign ir_load = ir_load_reg;
  assign pc_stop = pc_stop_reg;
  assign pc_wr   = pc_wr_reg;
  assign if_ban  = if_ban_reg;
  assign jump    = jump_reg;
  assign halted  = halted_reg;
  assign fault   = fault_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential, jump, branch, stalled branch,
// halt/resume, memory timeout and asynchronous reset during EXEC.
module tb_pc_sequencer;

  localparam int AW       = 8;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stall, mem_ready;
  logic             op_jump, op_branch, op_halt;
  logic [AW-1:0]    target;
  logic             cond_flag, resume;
  logic             mem_req, ir_load, pc_stop, pc_wr, if_ban, halted, fault;
  logic [AW-1:0]    jump;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0]    jump_model    = '0;
  logic [CNT_W-1:0] retired_model = '0;

  pc_sequencer #(.AW(AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .mem_ready(mem_ready),
    .op_jump(op_jump), .op_branch(op_branch), .op_halt(op_halt), .target(target),
    .cond_flag(cond_flag), .resume(resume), .mem_req(mem_req), .ir_load(ir_load),
    .pc_stop(pc_stop), .pc_wr(pc_wr), .if_ban(if_ban), .jump(jump),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entry: FETCH cycle observed. Exit: EXEC cycle observed with the op latched.
  task automatic to_exec(input string name, input int n_wait, input logic oj,
                         input logic ob, input logic oh, input logic [AW-1:0] tgt);
    check_eq({name, "/fetch_req"}, 32'(mem_req), 32'd1);
    mem_ready = 1'b0;
    tick;
    check_eq({name, "/wait_req"}, 32'(mem_req), 32'd1);
    check_eq({name, "/wait_stop"}, 32'(pc_stop), 32'd1);
    check_eq({name, "/wait_strobe"}, 32'({pc_wr, if_ban}), 32'd0);
    check_eq({name, "/jump_hold"}, 32'(jump), 32'(jump_model));
    for (int i = 0; i < n_wait; i++) begin
      mem_ready = 1'b0;
      tick;
    end
    check_eq({name, "/late_req"}, 32'(mem_req), 32'd1);
    check_eq({name, "/no_fault"}, 32'(fault), 32'd0);
    mem_ready = 1'b1;
    tick;
    check_eq({name, "/ir_load"}, 32'(ir_load), 32'd1);
    check_eq({name, "/decode_req"}, 32'(mem_req), 32'd0);
    mem_ready = 1'b0;
    op_jump = oj; op_branch = ob; op_halt = oh; target = tgt;
    tick;
    check_eq({name, "/ir_once"}, 32'(ir_load), 32'd0);
    check_eq({name, "/exec_stop"}, 32'(pc_stop), 32'd1);
    op_jump = 1'b0; op_branch = 1'b0; op_halt = 1'b0; target = '0;
  endtask

  task automatic finish_exec(input string name, input logic cf, input int n_stall,
                             input logic exp_wr, input logic exp_ban,
                             input logic [AW-1:0] exp_jump, input logic exp_halt);
    if (n_stall > 0) begin
      stall = 1'b1;
      cond_flag = ~cf;
      for (int i = 0; i < n_stall; i++) begin
        tick;
        check_eq({name, "/stall_stop"}, 32'(pc_stop), 32'd1);
        check_eq({name, "/stall_strobe"}, 32'({pc_wr, if_ban}), 32'd0);
        check_eq({name, "/stall_retired"}, 32'(retired), 32'(retired_model));
        cond_flag = cf;
      end
      stall = 1'b0;
    end
    cond_flag = cf;
    tick;
    if (!exp_halt) retired_model = retired_model + 16'd1;
    if (exp_wr || exp_ban) jump_model = exp_jump;
    check_eq({name, "/pc_stop"}, 32'(pc_stop), 32'(exp_halt));
    check_eq({name, "/pc_wr"}, 32'(pc_wr), 32'(exp_wr));
    check_eq({name, "/if_ban"}, 32'(if_ban), 32'(exp_ban));
    check_eq({name, "/retired"}, 32'(retired), 32'(retired_model));
    check_eq({name, "/halted"}, 32'(halted), 32'(exp_halt));
    check_eq({name, "/next_req"}, 32'(mem_req), 32'(!exp_halt));
    if (exp_wr || exp_ban) check_eq({name, "/jump"}, 32'(jump), 32'(exp_jump));
    $display("txn %s: pc_stop=%0b pc_wr=%0b if_ban=%0b jump=%02h halted=%0b retired=%0d",
             name, pc_stop, pc_wr, if_ban, jump, halted, retired);
    cond_flag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; mem_ready = 1'b0;
    op_jump = 1'b0; op_branch = 1'b0; op_halt = 1'b0; target = '0;
    cond_flag = 1'b0; resume = 1'b0;
    tick; tick;
    check_eq("rst/pc_stop", 32'(pc_stop), 32'd1);
    check_eq("rst/outs", 32'({mem_req, ir_load, pc_wr, if_ban, halted, fault}), 32'd0);
    check_eq("rst/jump", 32'(jump), 32'd0);
    check_eq("rst/retired", 32'(retired), 32'd0);

    rst = 1'b1;
    tick;
    check_eq("idle/req", 32'(mem_req), 32'd0);
    check_eq("idle/stop", 32'(pc_stop), 32'd1);
    start = 1'b1; stall = 1'b1;   // stall has no effect in IDLE
    tick;
    start = 1'b0; stall = 1'b0;

    to_exec("seq1", 1, 1'b0, 1'b0, 1'b0, 8'h00);
    finish_exec("seq1", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    to_exec("seq2", 1, 1'b0, 1'b0, 1'b0, 8'h00);
    finish_exec("seq2", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    to_exec("seq3", 1, 1'b0, 1'b0, 1'b0, 8'h00);
    finish_exec("seq3", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

    to_exec("jmp40", 1, 1'b1, 1'b0, 1'b0, 8'h40);
    finish_exec("jmp40", 1'b0, 0, 1'b1, 1'b0, 8'h40, 1'b0);
    to_exec("br05t", 1, 1'b0, 1'b1, 1'b0, 8'h05);
    finish_exec("br05t", 1'b1, 0, 1'b0, 1'b1, 8'h05, 1'b0);
    to_exec("br05n", 1, 1'b0, 1'b1, 1'b0, 8'h05);
    finish_exec("br05n", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

    // mem_ready arrives in the last allowed WAIT cycle
    to_exec("late", MAX_WAIT - 1, 1'b0, 1'b0, 1'b0, 8'h00);
    finish_exec("late", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

    to_exec("brstall", 1, 1'b0, 1'b1, 1'b0, 8'h22);
    finish_exec("brstall", 1'b1, 3, 1'b0, 1'b1, 8'h22, 1'b0);

    to_exec("halt", 1, 1'b1, 1'b0, 1'b1, 8'h77);
    finish_exec("halt", 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    start = 1'b1; stall = 1'b1;
    tick;
    check_eq("halt/start_ignored", 32'(halted), 32'd1);
    check_eq("halt/no_req", 32'(mem_req), 32'd0);
    start = 1'b0; stall = 1'b0; resume = 1'b1;
    tick;
    resume = 1'b0;
    check_eq("resume/req", 32'(mem_req), 32'd1);
    check_eq("resume/halted", 32'(halted), 32'd0);

    mem_ready = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) tick;
    check_eq("timeout/last_wait_fault", 32'(fault), 32'd0);
    check_eq("timeout/last_wait_req", 32'(mem_req), 32'd1);
    tick;
    check_eq("timeout/fault", 32'(fault), 32'd1);
    check_eq("timeout/req", 32'(mem_req), 32'd0);
    check_eq("timeout/stop", 32'(pc_stop), 32'd1);
    start = 1'b1; resume = 1'b1;
    tick; tick;
    start = 1'b0; resume = 1'b0;
    check_eq("fault/sticky", 32'(fault), 32'd1);
    check_eq("fault/req", 32'(mem_req), 32'd0);
    $display("txn fault: fault=%0b retired=%0d", fault, retired);
    #2 rst = 1'b0;
    #1;
    retired_model = '0;
    jump_model = '0;
    check_eq("fault_rst/fault", 32'(fault), 32'd0);
    check_eq("fault_rst/stop", 32'(pc_stop), 32'd1);
    check_eq("fault_rst/retired", 32'(retired), 32'd0);

    tick;
    rst = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    to_exec("rstx", 1, 1'b1, 1'b0, 1'b0, 8'h55);
    #3 rst = 1'b0;
    #1;
    check_eq("rstx/pc_stop", 32'(pc_stop), 32'd1);
    check_eq("rstx/pc_wr", 32'(pc_wr), 32'd0);
    check_eq("rstx/jump", 32'(jump), 32'd0);
    check_eq("rstx/retired", 32'(retired), 32'(retired_model));
    tick;
    check_eq("rstx/held_pc_wr", 32'(pc_wr), 32'd0);
    check_eq("rstx/held_req", 32'(mem_req), 32'd0);
    $display("txn rstx: pc_stop=%0b pc_wr=%0b retired=%0d", pc_stop, pc_wr, retired);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle instruction-cycle controller that drives the CPU program counter's control inputs (stop, pcWR, ifBan, jump) and the instruction-register load.
- Sequences fetch → wait-for-memory → decode → execute for an 8-bit-address CPU.
- Ensures the PC advances, jumps or branches exactly once per retired instruction.
- Handles memory-wait timeout, pipeline stall, halt/resume, and counts retired instructions.

Parameters:
AW, 8, address/jump-target width
MAX_WAIT, 15, cycles allowed in WAIT before FAULT (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  leave IDLE, begin fetching
stall  in  1  freeze sequencing while 1
mem_ready  in  1  instruction memory has valid data
op_jump  in  1  decoded: absolute jump
op_branch  in  1  decoded: relative branch
op_halt  in  1  decoded: halt
target  in  AW  jump address or branch offset from decoder
cond_flag  in  1  branch condition from ALU, sampled in EXEC
resume  in  1  leave HALT
mem_req  out  1  instruction fetch request
ir_load  out  1  one-cycle instruction-register load strobe
pc_stop  out  1  PC freeze (1 = PC holds)
pc_wr  out  1  PC absolute-load strobe
if_ban  out  1  PC relative-branch strobe
jump  out  AW  value presented to PC jump input
halted  out  1  in HALT
fault  out  1  memory timeout, sticky
retired  out  CNT_W  retired-instruction count

Behaviour:
- All outputs registered (Moore).
- Reset (rst=0, any time, asynchronous): state IDLE, pc_stop=1, all other outputs 0, retired=0, wait_cnt=0, latched op/target cleared.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, HALT, FAULT.
- IDLE: pc_stop=1. start=1 → FETCH.
- FETCH: mem_req=1 for one cycle, wait_cnt=0 → WAIT.
- WAIT: mem_req=1, wait_cnt increments each cycle.
  - mem_ready=1 → DECODE; ir_load=1 during the first DECODE cycle only.
  - wait_cnt reaches MAX_WAIT with mem_ready=0 → FAULT.
  - mem_ready takes priority in the same cycle wait_cnt hits MAX_WAIT.
- DECODE: latch op_jump/op_branch/op_halt/target/… → EXEC.
  - Op priority: halt > jump > branch > sequential.
- EXEC (exactly one cycle, unless stalled):
  - halt: no PC action → HALT; retired not incremented.
  - jump: pc_stop=0, pc_wr=1, jump=target.
  - branch with cond_flag=1: pc_stop=0, if_ban=1, jump=target.
  - branch with cond_flag=0, or sequential: pc_stop=0, pc_wr=0, if_ban=0.
  - Non-halt: retired += 1 (wraps at 2^CNT_W), → FETCH.
- pc_stop=0 only in EXEC. pc_wr and if_ban are never both 1.
- jump holds its last value outside EXEC; it is 0 after reset.
- HALT: halted=1, pc_stop=1. resume=1 → FETCH. start is ignored.
- FAULT: fault=1, pc_stop=1, mem_req=0. Exits only via reset.
- stall=1 in FETCH/WAIT/DECODE/EXEC:
  - State and wait_cnt are frozen.
  - pc_stop=1; ir_load, pc_wr, if_ban forced 0; mem_req holds its value.
  - A stalled EXEC performs its action in the first unstalled cycle.
  - cond_flag is sampled in that unstalled cycle.
- stall is ignored in IDLE, HALT and FAULT.
- Reset mid-EXEC aborts the instruction: no PC strobe, retired unchanged.

Test Plan:
1. Reset, start=1, mem_ready=1 two cycles after each mem_req, sequential ops → pc_stop=0 one cycle per instruction; retired=1,2,3; pc_wr=if_ban=0.
2. Jump with target=8'h40 → single cycle with pc_stop=0, pc_wr=1, jump=8'h40. Branch target=8'h05 with cond_flag=1 → if_ban=1, jump=8'h05. Same branch with cond_flag=0 → pc_stop=0 only.
3. op_halt=1 together with op_jump=1 → no pc_wr; halted=1; retired unchanged. resume=1 → mem_req=1 next cycle.
4. mem_ready held 0 → fault=1 after MAX_WAIT=15 WAIT cycles. start and resume have no effect. rst=0 clears fault.
5. stall=1 for 3 cycles during EXEC of a branch; cond_flag goes 0→1 during the stall → if_ban=1 in the first unstalled cycle; exactly one strobe.
6. rst=0 asserted mid-EXEC between clock edges → outputs clear immediately; pc_stop=1; retired unchanged from its pre-reset value.
